missile_launch_sched: RTL and testbench

//  Upstream launch scheduler for one enemy missile channel: decides when the missile engine fires.

---
 rtl/missile_launch_sched_if.sv | 24 ++
 rtl/missile_launch_sched.sv | 123 ++++++++++++
 tb/tb_missile_launch_sched.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/missile_launch_sched_if.sv
// Signal bundle between the enemy sprite / missile engine and the launch scheduler.
// The scheduler side is the slave; whatever drives the enemy inputs is the master.
interface missile_launch_sched_if;
  logic       frame_clk;
  logic       enable;
  logic       alive;
  logic [9:0] enemy_x;
  logic [9:0] enemy_y;
  logic       explored;
  logic       launch;
  logic [9:0] start_x;
  logic [9:0] start_y;
  logic       busy;

  modport master (
    output frame_clk, enable, alive, enemy_x, enemy_y, explored,
    input  launch, start_x, start_y, busy
  );

  modport slave (
    input  frame_clk, enable, alive, enemy_x, enemy_y, explored,
    output launch, start_x, start_y, busy
  );
endinterface

// File: rtl/missile_launch_sched.sv
// Launch scheduler for one enemy missile channel: frame-counted cooldown with LFSR jitter,
// position capture, one-cycle launch pulse, then wait for the missile to end or time out.
module missile_launch_sched #(
  parameter logic [4:0] COOLDOWN_FRAMES = 5'd20,
  parameter int         RAND_BITS       = 3,
  parameter logic [7:0] LFSR_SEED       = 8'hA5,
  parameter logic [9:0] Y_LAUNCH_MAX    = 10'd360,
  parameter logic [7:0] FLIGHT_TIMEOUT  = 8'd90
) (
  input  logic                   Clk,
  input  logic                   Reset,
  missile_launch_sched_if.slave  m
);

  typedef enum logic [1:0] {IDLE, COOLDOWN, LAUNCH, FLIGHT} state_e;

  localparam logic [7:0] JIT_MASK = 8'((1 << RAND_BITS) - 1);
  localparam logic [7:0] BASE     = (COOLDOWN_FRAMES == 5'd0) ? 8'd1 : {3'b000, COOLDOWN_FRAMES};

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic       armed_q, armed_d;
  logic [9:0] start_x_q, start_x_d;
  logic [9:0] start_y_q, start_y_d;
  logic       frame_q, fe_q;
  logic       launch_q, busy_q;
  logic [7:0] reload;
  logic [7:0] cnt_inc;
  logic       abort;

  assign reload  = BASE + (lfsr_q & JIT_MASK);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign abort   = !m.alive || !m.enable;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    start_x_d = start_x_q;
    start_y_d = start_y_q;
    lfsr_d    = fe_q ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;

    // Abort beats every other transition, but the LFSR above keeps stepping regardless.
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COOLDOWN;
          cnt_d   = reload;
        end
        COOLDOWN: begin
          if (fe_q) begin
            if (cnt_q <= 8'd1) begin
              if (m.enemy_y < Y_LAUNCH_MAX) begin
                start_x_d = m.enemy_x;
                start_y_d = m.enemy_y;
                state_d   = LAUNCH;
              end else begin
                cnt_d = reload;
              end
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        LAUNCH: begin
          state_d = FLIGHT;
          cnt_d   = 8'd0;
          armed_d = 1'b0;
        end
        FLIGHT: begin
          // armed only after the first frame in flight, so a leftover explored is ignored
          if (armed_q && m.explored) begin
            state_d = COOLDOWN;
            cnt_d   = reload;
          end else if (fe_q) begin
            armed_d = 1'b1;
            cnt_d   = cnt_inc;
            if (cnt_inc == FLIGHT_TIMEOUT) begin
              state_d = COOLDOWN;
              cnt_d   = reload;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      lfsr_q    <= LFSR_SEED;
      armed_q   <= 1'b0;
      start_x_q <= 10'd0;
      start_y_q <= 10'd0;
      frame_q   <= 1'b0;
      fe_q      <= 1'b0;
      launch_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      armed_q   <= armed_d;
      start_x_q <= start_x_d;
      start_y_q <= start_y_d;
      frame_q   <= m.frame_clk;
      fe_q      <= m.frame_clk & ~frame_q;
      launch_q  <= (state_d == LAUNCH);
      busy_q    <= (state_d == LAUNCH) || (state_d == FLIGHT);
    end
  end

  assign m.launch  = launch_q;
  assign m.busy    = busy_q;
  assign m.start_x = start_x_q;
  assign m.start_y = start_y_q;

endmodule

// File: tb/tb_missile_launch_sched.sv
// Bench for missile_launch_sched: two instances (no jitter / jitter with short timeout)
// compared every cycle against a frame-level reference model, plus directed scenario checks.
module tb_missile_launch_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_clk = 1'b0, enable = 1'b0, alive = 1'b0, explored = 1'b0;
  logic [9:0] ex = 10'd0, ey = 10'd0;

  int vectors = 0;
  int errors  = 0;
  int n_launch0 = 0;

  always #5 clk = ~clk;

  missile_launch_sched_if if0 ();
  missile_launch_sched_if if1 ();

  assign if0.frame_clk = frame_clk;
  assign if0.enable    = enable;
  assign if0.alive     = alive;
  assign if0.enemy_x   = ex;
  assign if0.enemy_y   = ey;
  assign if0.explored  = explored;
  assign if1.frame_clk = frame_clk;
  assign if1.enable    = enable;
  assign if1.alive     = alive;
  assign if1.enemy_x   = ex;
  assign if1.enemy_y   = ey;
  assign if1.explored  = explored;

  missile_launch_sched #(
    .COOLDOWN_FRAMES(5'd3), .RAND_BITS(0), .LFSR_SEED(8'hA5),
    .Y_LAUNCH_MAX(10'd360), .FLIGHT_TIMEOUT(8'd90)
  ) dut0 (.Clk(clk), .Reset(rst), .m(if0));

  missile_launch_sched #(
    .COOLDOWN_FRAMES(5'd3), .RAND_BITS(3), .LFSR_SEED(8'hA5),
    .Y_LAUNCH_MAX(10'd360), .FLIGHT_TIMEOUT(8'd5)
  ) dut1 (.Clk(clk), .Reset(rst), .m(if1));

  // Reference model: phase of each channel, frames left to wait, frames flown
  localparam int P_IDLE = 0, P_WAIT = 1, P_LAUNCH = 2, P_FLY = 3;
  int         base  [2] = '{3, 3};
  int         jmask [2] = '{0, 7};
  int         tout  [2] = '{90, 5};
  int         ph    [2];
  int         left  [2];
  int         flown [2];
  bit         armed [2];
  logic [7:0] lf    [2];
  int         sx    [2];
  int         sy    [2];
  bit         fc_prev, fe_now;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    bit         fe;
    logic [7:0] old;
    int         rl;
    if (rst) begin
      fc_prev = 1'b0;
      fe_now  = 1'b0;
      for (int k = 0; k < 2; k++) begin
        ph[k] = P_IDLE; left[k] = 0; flown[k] = 0; armed[k] = 1'b0;
        lf[k] = 8'hA5; sx[k] = 0; sy[k] = 0;
      end
      return;
    end
    fe      = fe_now;
    fe_now  = frame_clk && !fc_prev;
    fc_prev = frame_clk;
    for (int k = 0; k < 2; k++) begin
      old = lf[k];
      if (fe) lf[k] = lfsr_next(old);
      rl = base[k] + (int'(old) & jmask[k]);
      if (!alive || !enable) begin
        ph[k] = P_IDLE;
      end else if (ph[k] == P_IDLE) begin
        ph[k] = P_WAIT; left[k] = rl;
      end else if (ph[k] == P_WAIT) begin
        if (fe) begin
          if (left[k] > 1) left[k]--;
          else if (ey < 10'd360) begin sx[k] = ex; sy[k] = ey; ph[k] = P_LAUNCH; end
          else left[k] = rl;
        end
      end else if (ph[k] == P_LAUNCH) begin
        ph[k] = P_FLY; flown[k] = 0; armed[k] = 1'b0;
      end else begin
        if (armed[k] && explored) begin
          ph[k] = P_WAIT; left[k] = rl;
        end else if (fe) begin
          armed[k] = 1'b1;
          flown[k] = (flown[k] < 255) ? flown[k] + 1 : 255;
          if (flown[k] == tout[k]) begin ph[k] = P_WAIT; left[k] = rl; end
        end
      end
    end
  endtask

  // Timeout / jitter interval tracking on the jittered channel
  bit t6_on = 1'b0;
  bit cd_ok = 1'b0, fl_ok = 1'b0, busy_prev1 = 1'b0;
  int cd_n = 0, fl_n = 0, exp_cd = 0, t6_hits = 0;

  always @(posedge clk) begin
    model_step();
    #2;
    chk("d0.launch",  if0.launch,  (ph[0] == P_LAUNCH));
    chk("d0.busy",    if0.busy,    (ph[0] == P_LAUNCH || ph[0] == P_FLY));
    chk("d0.start_x", if0.start_x, sx[0]);
    chk("d0.start_y", if0.start_y, sy[0]);
    chk("d1.launch",  if1.launch,  (ph[1] == P_LAUNCH));
    chk("d1.busy",    if1.busy,    (ph[1] == P_LAUNCH || ph[1] == P_FLY));
    chk("d1.start_x", if1.start_x, sx[1]);
    chk("d1.start_y", if1.start_y, sy[1]);
    if (if0.launch === 1'b1) n_launch0++;
    if (!t6_on) begin
      cd_ok = 1'b0;
      fl_ok = 1'b0;
    end else begin
      if (if1.launch === 1'b1) begin
        if (cd_ok) begin
          chk("t6.cd_range", (cd_n >= 3 && cd_n <= 10), 1);
          chk("t6.cd_frames", cd_n, exp_cd);
          t6_hits++;
        end
        cd_ok = 1'b0; fl_ok = 1'b1; fl_n = 0;
      end
      if (busy_prev1 && if1.busy === 1'b0) begin
        if (fl_ok) chk("t6.flight_frames", fl_n, 5);
        fl_ok = 1'b0; cd_ok = 1'b1; cd_n = 0; exp_cd = left[1];
      end
      if (fe_now) begin fl_n++; cd_n++; end
    end
    busy_prev1 = (if1.busy === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1; step(4);
      frame_clk = 1'b0; step(4);
    end
  endtask

  // Raise the frame that must fire dut0; launch shows two negedges after the rise
  task automatic launch_frame(input string tag, input int x, input int y);
    frame_clk = 1'b1;
    step(1);
    chk({tag, ".not_early"}, if0.launch, 0);
    step(1);
    chk({tag, ".launch"}, if0.launch, 1);
    chk({tag, ".busy"}, if0.busy, 1);
    chk({tag, ".start_x"}, if0.start_x, x);
    chk({tag, ".start_y"}, if0.start_y, y);
  endtask

  initial begin
    int n0;
    int r;
    // T1: reset with frame_clk toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      frame_clk = ~frame_clk;
    end
    step(1);
    chk("t1.launch", if0.launch, 0);
    chk("t1.busy", if0.busy, 0);
    chk("t1.start_x", if0.start_x, 0);
    chk("t1.start_y", if1.start_y, 0);
    rst = 1'b0; frame_clk = 1'b0;
    step(2);
    chk("t1.busy_after", if1.busy, 0);
    chk("model.lfsr_next", lfsr_next(8'hA5), 8'h4A);

    // T2: basic launch
    alive = 1'b1; enable = 1'b1; ex = 10'd100; ey = 10'd50;
    step(3);
    chk("model.first_reload_jitter", left[1], 8);
    n0 = n_launch0;
    frames(2);
    chk("t2.no_early_launch", n_launch0 - n0, 0);
    launch_frame("t2", 100, 50);
    step(1);
    chk("t2.pulse_width", if0.launch, 0);
    chk("t2.busy_holds", if0.busy, 1);
    chk("t2.one_launch", n_launch0 - n0, 1);

    // T3: stale explored held through launch
    explored = 1'b1;
    frame_clk = 1'b0;
    step(4);
    chk("t3.stale_ignored", if0.busy, 1);
    frame_clk = 1'b1;
    step(2);
    chk("t3.busy_at_fe1", if0.busy, 1);
    step(1);
    chk("t3.busy_drop", if0.busy, 0);
    frame_clk = 1'b0;
    step(4);
    frames(2);
    launch_frame("t3", 100, 50);

    // T4: Y gate
    ey = 10'd360;
    step(2);
    frame_clk = 1'b0;
    step(4);
    n0 = n_launch0;
    frames(10);
    chk("t4.blocked", n_launch0 - n0, 0);
    ey = 10'd200;
    frames(3);
    chk("t4.released", n_launch0 - n0, 1);
    chk("t4.start_x", if0.start_x, 100);
    chk("t4.start_y", if0.start_y, 200);

    // T5: abort after launch
    enable = 1'b0; step(2);
    enable = 1'b1; explored = 1'b0; step(2);
    frames(2);
    launch_frame("t5a", 100, 200);
    step(2);
    alive = 1'b0;
    step(1);
    chk("t5.busy_abort", if0.busy, 0);
    chk("t5.launch_abort", if0.launch, 0);
    chk("t5.start_x_held", if0.start_x, 100);
    chk("t5.start_y_held", if0.start_y, 200);
    frame_clk = 1'b0;
    step(4);
    n0 = n_launch0;
    frames(5);
    chk("t5.no_launch_dead", n_launch0 - n0, 0);
    alive = 1'b1;
    step(2);
    frames(2);
    launch_frame("t5b", 100, 200);

    // Reset in the middle of flight
    step(2);
    chk("rst.in_flight", if0.busy, 1);
    rst = 1'b1;
    step(1);
    chk("rst.launch", if0.launch, 0);
    chk("rst.busy", if0.busy, 0);
    chk("rst.start_x", if0.start_x, 0);
    chk("rst.start_y", if0.start_y, 0);
    rst = 1'b0; frame_clk = 1'b0;
    step(2);

    // T6: timeout and jitter with randomized frame lengths
    explored = 1'b0;
    t6_on = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ex = 10'($urandom_range(0, 1023));
        ey = 10'($urandom_range(0, 359));
      end
      frame_clk = 1'b1; step(int'($urandom_range(1, 5)));
      frame_clk = 1'b0; step(int'($urandom_range(2, 8)));
    end
    t6_on = 1'b0;
    chk("t6.intervals_seen", (t6_hits > 0), 1);

    // Mixed random: aborts, Y-blocked positions, explored, resets, fast frames
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        rst = 1'b1; step(int'($urandom_range(1, 3))); rst = 1'b0;
      end else if (r < 12) alive = 1'b0;
      else if (r < 17) enable = 1'b0;
      else begin alive = 1'b1; enable = 1'b1; end
      explored = ($urandom_range(0, 2) == 0);
      ex = 10'($urandom_range(0, 1023));
      ey = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(360, 1023)) : 10'($urandom_range(0, 359));
      frame_clk = 1'b1; step(int'($urandom_range(1, 4)));
      frame_clk = 1'b0; step(int'($urandom_range(1, 6)));
    end
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
